mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the processor data bus, downstream of the core.
- Consumes the core's data-side outputs: MemWrite, ALUResult used as the address, and WriteData.
- Returns status through a combinational read port, so single-cycle loads work unchanged.
- Buffers bytes in a small FIFO and serialises them 8N1 on TX.

---
 rtl/mmio_uart_tx.sv | 137 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a combinational status read port.
// Define UART_TX_PARITY_EN to insert an even-parity bit, gated by CTRL bit1.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0C00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Sel,
    output logic [31:0] ReadData,
    output logic        TX,
    output logic        TxIrq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t state, nstate;
    logic [BW-1:0] cnt, ncnt;
    logic [2:0] idx, nidx;
    logic [7:0] shift, nshift;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, ncount;
    logic [1:0] off;
    logic wr, push_req, push_ok, pop, full, empty, start_ok, ovf, en;
    logic unused;

    assign Sel = ALUResult[31:4] == BASE_ADDR[31:4];
    assign off = ALUResult[3:2];
    assign wr = MemWrite & Sel;
    assign push_req = wr & (off == 2'd0);
    assign full = count[AW];
    assign empty = count == '0;
    assign start_ok = en & ~empty;
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign push_ok = push_req & (~full | pop);
    assign ncount = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    assign unused = ^{ALUResult[1:0], WriteData[31:8]};

`ifdef UART_TX_PARITY_EN
    logic par_en, par_bit;
    always_ff @(posedge CLK) begin
        if (Reset) begin
            par_en <= 1'b1;
            par_bit <= 1'b0;
        end else begin
            if (wr & (off == 2'd2)) par_en <= WriteData[1];
            if (pop) par_bit <= ^mem[rd_ptr];
        end
    end
    assign TX = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
`else
    logic par_en;
    assign par_en = 1'b0;
    assign TX = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif

    assign ReadData = !Sel ? '0 :
                      off == 2'd1 ? {24'd0, 4'(count), ovf, empty, full, state != IDLE} :
                      off == 2'd2 ? {30'd0, par_en, en} : '0;

    always_comb begin
        nstate = state;
        ncnt = cnt;
        nidx = idx;
        nshift = shift;
        pop = 1'b0;
        if (state != IDLE && cnt != '0) ncnt = cnt - 1'b1;
        else case (state)
            IDLE, STOP: begin
                nstate = start_ok ? START : IDLE;
                pop = start_ok;
                ncnt = start_ok ? RELOAD : '0;
                nshift = start_ok ? mem[rd_ptr] : shift;
            end
            START: begin
                nstate = DATA;
                ncnt = RELOAD;
                nidx = '0;
            end
            DATA: begin
                ncnt = RELOAD;
                nidx = idx + 1'b1;
                nshift = shift >> 1;
`ifdef UART_TX_PARITY_EN
                nstate = idx != 3'd7 ? DATA : par_en ? PARITY : STOP;
`else
                nstate = idx != 3'd7 ? DATA : STOP;
`endif
            end
            default: begin
                nstate = STOP;
                ncnt = RELOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ovf <= 1'b0;
            en <= 1'b1;
            TxIrq <= 1'b1;
        end else begin
            state <= nstate;
            cnt <= ncnt;
            idx <= nidx;
            shift <= nshift;
            count <= ncount;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req & full & ~pop) ovf <= 1'b1;
            else if (wr & (off == 2'd1) & WriteData[3]) ovf <= 1'b0;
            if (wr & (off == 2'd2)) en <= WriteData[0];
            TxIrq <= (ncount == '0) && (nstate == IDLE);
        end
    end

    always_ff @(posedge CLK) if (push_ok) mem[wr_ptr] <= WriteData[7:0];
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register-access vector table plus a TX line monitor scoring decoded frames against a byte queue.
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    localparam logic [31:0] BASE = 32'h0000_0C00;
    localparam logic [31:0] STAT = BASE + 32'h4;
    localparam logic [31:0] CTRL = BASE + 32'h8;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] CTRL_RST = 32'h3;
`else
    localparam logic [31:0] CTRL_RST = 32'h1;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        push;
        logic        sel;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    logic CLK = 0, Reset = 1, MemWrite = 0;
    logic [31:0] ALUResult = STAT, WriteData = 0;
    logic Sel, TX, TxIrq;
    logic [31:0] ReadData;
    int total = 0, bad = 0, cyc = 0, prev_start = 0, last_start = 0, mcnt = 0;
    logic par_on = CTRL_RST[1], in_frame = 0, mpar = 0;
    logic [7:0] mbyte = 0, exp_b = 0;
    logic [7:0] sb[$];

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .Sel(Sel), .ReadData(ReadData), .TX(TX), .TxIrq(TxIrq)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int flen();
        return par_on ? 11 * CPB : 10 * CPB;
    endfunction

    function automatic logic line_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && par_on) return ^b;
        return 1'b1;
    endfunction

    // Frame decoder: samples each bit mid-period and pops the scoreboard at the stop bit.
    always @(negedge CLK) begin
        if (Reset) in_frame = 0;
        else if (!in_frame) begin
            if (!TX) begin
                in_frame = 1;
                mcnt = 0;
                prev_start = last_start;
                last_start = cyc;
            end
        end else begin
            mcnt++;
            if (mcnt % CPB == CPB / 2) begin
                if (mcnt / CPB == 0) chk("mon_start", TX, 0);
                else if (mcnt / CPB <= 8) mbyte[mcnt / CPB - 1] = TX;
                else if (mcnt / CPB == 9 && par_on) mpar = TX;
            end
            if (mcnt == flen() - 1) begin
                in_frame = 0;
                chk("mon_stop", TX, 1);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_extra: unexpected frame byte %h", mbyte);
                end else begin
                    exp_b = sb.pop_front();
                    chk("mon_byte", mbyte, exp_b);
                    if (par_on) chk("mon_parity", mpar, ^exp_b);
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        MemWrite = 1;
        ALUResult = a;
        WriteData = d;
        @(posedge CLK);
        #1;
        MemWrite = 0;
        ALUResult = STAT;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        wr(BASE, {24'd0, b});
        sb.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 0;
        for (int i = 0; i < 1500 && !done; i++) begin
            @(negedge CLK);
            done = sb.size() == 0 && TxIrq && !in_frame;
        end
        chk(name, done, 1);
    endtask

    task automatic send_watch(input logic [7:0] b, input string name);
        int n;
        n = flen();
        tx_byte(b);
        @(negedge CLK);
        chk({name, "_lat_tx"}, TX, 1);
        chk({name, "_lat_irq"}, TxIrq, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk($sformatf("%s_line%0d", name, i), TX, line_bit(b, i / CPB));
            if (i == 0 || i == n - 1) begin
                chk($sformatf("%s_busy%0d", name, i), ReadData, 32'h05);
                chk($sformatf("%s_irq%0d", name, i), TxIrq, 0);
            end
        end
        @(negedge CLK);
        chk({name, "_end_status"}, ReadData, 32'h04);
        chk({name, "_end_irq"}, TxIrq, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[19];
        logic quiet;
        vt[0]  = '{1'b0, CTRL,              32'h0,         1'b0, 1'b1, CTRL_RST, 1'b1};
        vt[1]  = '{1'b0, STAT,              32'h0,         1'b0, 1'b1, 32'h04,   1'b1};
        vt[2]  = '{1'b0, BASE + 32'h10,     32'h0,         1'b0, 1'b0, 32'h0,    1'b1};
        vt[3]  = '{1'b0, BASE + 32'hC,      32'h0,         1'b0, 1'b1, 32'h0,    1'b1};
        vt[4]  = '{1'b0, BASE,              32'h0,         1'b0, 1'b1, 32'h0,    1'b1};
        vt[5]  = '{1'b1, CTRL,              32'h0,         1'b0, 1'b1, CTRL_RST, 1'b1};
        vt[6]  = '{1'b0, CTRL,              32'h0,         1'b0, 1'b1, 32'h0,    1'b1};
        vt[7]  = '{1'b1, BASE,              32'h11,        1'b1, 1'b1, 32'h0,    1'b1};
        vt[8]  = '{1'b1, BASE + 32'h1,      32'h22,        1'b1, 1'b1, 32'h0,    1'b0};
        vt[9]  = '{1'b1, BASE + 32'h2,      32'hABCD_EF33, 1'b1, 1'b1, 32'h0,    1'b0};
        vt[10] = '{1'b1, BASE + 32'h3,      32'h44,        1'b1, 1'b1, 32'h0,    1'b0};
        vt[11] = '{1'b1, BASE,              32'h55,        1'b0, 1'b1, 32'h0,    1'b0};
        vt[12] = '{1'b0, STAT,              32'h0,         1'b0, 1'b1, 32'h4A,   1'b0};
        vt[13] = '{1'b0, BASE - 32'h4,      32'h0,         1'b0, 1'b0, 32'h0,    1'b0};
        vt[14] = '{1'b1, STAT,              32'h8,         1'b0, 1'b1, 32'h4A,   1'b0};
        vt[15] = '{1'b0, STAT,              32'h0,         1'b0, 1'b1, 32'h42,   1'b0};
        vt[16] = '{1'b1, BASE + 32'h10,     32'h0,         1'b0, 1'b0, 32'h0,    1'b0};
        vt[17] = '{1'b1, 32'h0000_0D00,     32'h99,        1'b0, 1'b0, 32'h0,    1'b0};
        vt[18] = '{1'b0, STAT,              32'h0,         1'b0, 1'b1, 32'h42,   1'b0};

        repeat (2) @(negedge CLK);
        chk("rst_tx", TX, 1);
        chk("rst_irq", TxIrq, 1);
        chk("rst_status", ReadData, 32'h04);
        Reset = 0;

        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            MemWrite = vt[i].we;
            ALUResult = vt[i].addr;
            WriteData = vt[i].wd;
            #1;
            chk($sformatf("vec%0d_sel", i), Sel, vt[i].sel);
            chk($sformatf("vec%0d_rd", i), ReadData, vt[i].rd);
            chk($sformatf("vec%0d_irq", i), TxIrq, vt[i].irq);
            chk($sformatf("vec%0d_tx", i), TX, 1);
            if (vt[i].push) sb.push_back(vt[i].wd[7:0]);
        end
        @(negedge CLK);
        MemWrite = 0;
        ALUResult = STAT;

        wr(CTRL, 32'h3);
        par_on = CTRL_RST[1];
        ALUResult = CTRL;
        #1;
        chk("ctrl_reenable", ReadData, CTRL_RST);
        ALUResult = STAT;
        wait_idle("drain_table");

        send_watch(8'h55, "f55");

        tx_byte(8'hA3);
        tx_byte(8'h0F);
        repeat (10) @(negedge CLK);
        chk("b2b_status", ReadData, 32'h11);
        wait_idle("b2b_drain");
        chk("b2b_gap", last_start - prev_start, flen());

`ifdef UART_TX_PARITY_EN
        send_watch(8'h07, "par07");
        wr(CTRL, 32'h1);
        par_on = 0;
        send_watch(8'h07, "nopar07");
`endif

        tx_byte(8'h5A);
        tx_byte(8'hC3);
        tx_byte(8'h3C);
        repeat (6) @(negedge CLK);
        chk("pre_rst_status", ReadData, 32'h21);
        Reset = 1;
        @(negedge CLK);
        chk("midrst_tx", TX, 1);
        chk("midrst_status", ReadData, 32'h04);
        chk("midrst_irq", TxIrq, 1);
        @(negedge CLK);
        sb.delete();
        par_on = CTRL_RST[1];
        Reset = 0;
        quiet = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) quiet = 0;
        end
        chk("midrst_quiet", quiet, 1);
        chk("midrst_status_after", ReadData, 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
